core_run_ctrl: RTL and testbench

Run controller for the tiny accumulator processor: it loads the 16-byte instruction memory over a byte-stream handshake, clears the datapath, and then sequences execution in free-run, single-step or halt modes. It sits between the board I/O and the core. It drives the core's instruction-memory write port, a datapath clear pulse and a global update enable for pc, acc and dmem. It also counts executed instructions for display.

---
 rtl/tiny_pkg.sv | 33 +++
 rtl/sat_counter.sv | 20 ++
 rtl/core_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_core_run_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_pkg.sv
// Shared definitions for the tiny accumulator processor: memory geometry,
// run-controller state encodings and command opcodes.
package tiny_pkg;

    localparam int IMEM_SZ = 16;
    localparam int INST_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_RUN   = 3'd3,
        ST_PAUSE = 3'd4,
        ST_STEP  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    localparam logic [1:0] CMD_LOAD = 2'd0;
    localparam logic [1:0] CMD_RUN  = 2'd1;
    localparam logic [1:0] CMD_STEP = 2'd2;
    localparam logic [1:0] CMD_HALT = 2'd3;

    // Address width for a memory of the given depth; never narrower than 1 bit.
    function automatic int CLOG2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller: streams the program into instruction memory, clears the
// datapath and sequences free-run / single-step / halt execution.
//
//   state  | meaning
//   IDLE   | after reset, waiting for a command
//   LOAD   | accepting instruction bytes into imem
//   CLEAR  | one-cycle datapath clear, then go to after-clear target
//   RUN    | core enabled every cycle
//   PAUSE  | core stopped, resumable
//   STEP   | core enabled for exactly one cycle
//   DONE   | core reached its final instruction
module core_run_ctrl #(
    parameter int IMEM_SZ = tiny_pkg::IMEM_SZ,
    parameter int INST_W  = tiny_pkg::INST_W,
    parameter int CNT_W   = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    input  logic [1:0]                            cmd_op,
    output logic                                  cmd_ready,
    input  logic                                  byte_valid,
    input  logic [INST_W-1:0]                     byte_data,
    output logic                                  byte_ready,
    output logic                                  imem_we,
    output logic [tiny_pkg::CLOG2(IMEM_SZ)-1:0]   imem_waddr,
    output logic [INST_W-1:0]                     imem_wdata,
    output logic                                  core_clr,
    output logic                                  core_en,
    input  logic                                  core_halted,
    output logic [2:0]                            state_out,
    output logic [CNT_W-1:0]                      exec_cnt
);

    import tiny_pkg::*;

    localparam int AW = CLOG2(IMEM_SZ);

    state_t        state;
    state_t        state_nxt;
    state_t        after_clr;
    state_t        after_clr_nxt;
    logic [AW-1:0] waddr_cnt;
    logic          cmd_acc;
    logic          byte_hs;
    logic          last_byte;

    assign cmd_acc   = cmd_valid && cmd_ready;
    assign byte_hs   = byte_valid && byte_ready;
    assign last_byte = (waddr_cnt == AW'(IMEM_SZ - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            after_clr <= ST_PAUSE;
        end else begin
            state     <= state_nxt;
            after_clr <= after_clr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        after_clr_nxt = after_clr;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        CMD_LOAD: state_nxt = ST_LOAD;
                        CMD_RUN: begin
                            state_nxt     = ST_CLEAR;
                            after_clr_nxt = ST_RUN;
                        end
                        CMD_STEP: begin
                            state_nxt     = ST_CLEAR;
                            after_clr_nxt = ST_PAUSE;
                        end
                        default: state_nxt = state;
                    endcase
                end
            end
            ST_LOAD: begin
                if (byte_hs && last_byte) begin
                    state_nxt     = ST_CLEAR;
                    after_clr_nxt = ST_PAUSE;
                end
            end
            ST_CLEAR: state_nxt = after_clr;
            ST_RUN: begin
                // The final instruction wins over a simultaneous HALT.
                if (core_halted) begin
                    state_nxt = ST_DONE;
                end else if (cmd_acc && (cmd_op == CMD_HALT)) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        CMD_LOAD: state_nxt = ST_LOAD;
                        CMD_RUN:  state_nxt = ST_RUN;
                        CMD_STEP: state_nxt = ST_STEP;
                        default:  state_nxt = state;
                    endcase
                end
            end
            ST_STEP: state_nxt = core_halted ? ST_DONE : ST_PAUSE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        byte_ready = 1'b0;
        if (!rst) begin
            cmd_ready  = (state == ST_IDLE) || (state == ST_RUN) ||
                         (state == ST_PAUSE) || (state == ST_DONE);
            byte_ready = (state == ST_LOAD);
        end
        core_clr  = (state == ST_CLEAR);
        core_en   = (state == ST_RUN) || (state == ST_STEP);
        state_out = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_cnt  <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= byte_hs;
            if (byte_hs) begin
                imem_waddr <= waddr_cnt;
                imem_wdata <= byte_data;
                waddr_cnt  <= last_byte ? '0 : waddr_cnt + AW'(1);
            end else if ((state != ST_LOAD) && (state_nxt == ST_LOAD)) begin
                waddr_cnt <= '0;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_exec_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (core_clr),
        .inc  (core_en),
        .count(exec_cnt)
    );

endmodule

// File: tb/tb_core_run_ctrl.sv
// Self-checking bench for core_run_ctrl: imem writes are scoreboarded,
// state/counter behaviour is checked against hand-derived expectations.
module tb_core_run_ctrl;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_HALT = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic       cmd_ready;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'd0;
    logic       byte_ready;
    logic       imem_we;
    logic [3:0] imem_waddr;
    logic [7:0] imem_wdata;
    logic       core_clr;
    logic       core_en;
    logic       core_halted = 1'b0;
    logic [2:0] state_out;
    logic [7:0] exec_cnt;

    int checks   = 0;
    int failures = 0;
    int en_cnt   = 0;
    int clr_cnt  = 0;
    int base_en;
    int base_clr;
    logic [11:0] wr_q[$];

    core_run_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_op     (cmd_op),
        .cmd_ready  (cmd_ready),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_clr   (core_clr),
        .core_en    (core_en),
        .core_halted(core_halted),
        .state_out  (state_out),
        .exec_cnt   (exec_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every imem_we must match the oldest expected write.
    always @(negedge clk) begin
        if (core_en) en_cnt++;
        if (core_clr) clr_cnt++;
        if (imem_we) begin
            if (wr_q.size() == 0) begin
                check("wr_extra", 32'(imem_we), 32'd0);
            end else begin
                logic [11:0] e;
                e = wr_q.pop_front();
                check("wr_addr", 32'(imem_waddr), 32'(e[11:8]));
                check("wr_data", 32'(imem_wdata), 32'(e[7:0]));
            end
        end
    end

    task automatic do_cmd(input logic [1:0] op);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called on a negedge in LOAD; leaves the bench on the negedge after the last handshake.
    task automatic stream(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = base - 8'(4 * i);
            check("byte_ready_load", 32'(byte_ready), 32'd1);
            byte_valid = 1'b1;
            byte_data  = d;
            wr_q.push_back({4'(i), d});
            @(negedge clk);
        end
        byte_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_waddr", 32'(imem_waddr), 32'd0);
        check("rst_wdata", 32'(imem_wdata), 32'd0);
        check("rst_clr", 32'(core_clr), 32'd0);
        check("rst_en", 32'(core_en), 32'd0);
        check("rst_cnt", 32'(exec_cnt), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        do_cmd(OP_HALT);
        check("idle_halt", 32'(state_out), 32'd0);

        // Full program load
        base_clr = clr_cnt;
        base_en  = en_cnt;
        do_cmd(OP_LOAD);
        check("load_state", 32'(state_out), 32'd1);
        check("load_cmd_ready", 32'(cmd_ready), 32'd0);
        stream(16, 8'h1B);
        check("load_clear_state", 32'(state_out), 32'd2);
        check("load_clear_byte_ready", 32'(byte_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("load_pause_state", 32'(state_out), 32'd4);
        check("load_clr_pulses", 32'(clr_cnt - base_clr), 32'd1);
        check("load_no_en", 32'(en_cnt - base_en), 32'd0);
        check("load_wr_drain", 32'(wr_q.size()), 32'd0);

        // Three single steps
        base_en = en_cnt;
        for (int k = 0; k < 3; k++) begin
            do_cmd(OP_STEP);
            check("step_state", 32'(state_out), 32'd5);
            @(negedge clk);
            check("step_back_pause", 32'(state_out), 32'd4);
        end
        @(negedge clk);
        check("step_en_cycles", 32'(en_cnt - base_en), 32'd3);
        check("step_cnt", 32'(exec_cnt), 32'd3);

        // RUN from IDLE until core_halted
        do_reset(2);
        base_en  = en_cnt;
        base_clr = clr_cnt;
        do_cmd(OP_RUN);
        check("run_clear_state", 32'(state_out), 32'd2);
        check("run_clear_pulse", 32'(core_clr), 32'd1);
        @(negedge clk);
        check("run_state", 32'(state_out), 32'd3);
        check("run_en", 32'(core_en), 32'd1);
        repeat (10) @(negedge clk);
        core_halted = 1'b1;
        @(negedge clk);
        core_halted = 1'b0;
        check("run_done_state", 32'(state_out), 32'd6);
        check("run_done_en", 32'(core_en), 32'd0);
        @(negedge clk);
        check("run_en_cycles", 32'(en_cnt - base_en), 32'd11);
        check("run_cnt", 32'(exec_cnt), 32'd11);
        check("run_clr_pulses", 32'(clr_cnt - base_clr), 32'd1);

        // HALT coinciding with core_halted
        do_cmd(OP_RUN);
        @(negedge clk);
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_op      = OP_HALT;
        core_halted = 1'b1;
        @(negedge clk);
        cmd_valid   = 1'b0;
        core_halted = 1'b0;
        check("halt_race_state", 32'(state_out), 32'd6);
        check("halt_race_cnt", 32'(exec_cnt), 32'd2);

        // Reset in the middle of a load, then reload from address 0
        do_reset(2);
        do_cmd(OP_LOAD);
        stream(5, 8'hC3);
        rst = 1'b1;
        @(negedge clk);
        check("midload_state", 32'(state_out), 32'd0);
        check("midload_byte_ready", 32'(byte_ready), 32'd0);
        check("midload_waddr", 32'(imem_waddr), 32'd0);
        check("midload_we", 32'(imem_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midload_idle", 32'(state_out), 32'd0);
        check("midload_wr_drain", 32'(wr_q.size()), 32'd0);
        do_cmd(OP_LOAD);
        stream(16, 8'h5A);
        @(negedge clk);
        @(negedge clk);
        check("reload_pause", 32'(state_out), 32'd4);
        check("reload_cnt", 32'(exec_cnt), 32'd0);

        // Long run saturates the counter; HALT then RUN resumes without clear
        base_clr = clr_cnt;
        do_cmd(OP_RUN);
        check("resume_state", 32'(state_out), 32'd3);
        check("resume_cnt0", 32'(exec_cnt), 32'd0);
        repeat (300) @(negedge clk);
        check("sat_cnt", 32'(exec_cnt), 32'd255);
        do_cmd(OP_LOAD);
        check("run_drop_load", 32'(state_out), 32'd3);
        do_cmd(OP_HALT);
        check("halt_pause", 32'(state_out), 32'd4);
        check("halt_pause_en", 32'(core_en), 32'd0);
        do_cmd(OP_RUN);
        check("resume2_state", 32'(state_out), 32'd3);
        check("resume2_clr", 32'(core_clr), 32'd0);
        @(negedge clk);
        check("resume_no_clr", 32'(clr_cnt - base_clr), 32'd0);
        check("sat_hold", 32'(exec_cnt), 32'd255);
        core_halted = 1'b1;
        @(negedge clk);
        core_halted = 1'b0;
        check("final_done", 32'(state_out), 32'd6);

        @(negedge clk);
        check("final_wr_drain", 32'(wr_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
